// File: rtl/ascii_num_parser_if.sv
// Character-stream in / signed-result out handshake bundle for ascii_num_parser.
// slave = parser side, master = producer/consumer side.
interface ascii_num_parser_if #(
    parameter int DATA_WIDTH = 32
);
    logic                         clear;
    logic                         start;
    logic                         hex_mode;
    logic [7:0]                   char_in;
    logic                         char_valid;
    logic                         char_ready;
    logic                         num_end;
    logic signed [DATA_WIDTH-1:0] result;
    logic                         result_valid;
    logic                         result_ready;
    logic                         err;
    logic                         overflow;

    modport slave (
        input  clear, start, hex_mode, char_in, char_valid, num_end, result_ready,
        output char_ready, result, result_valid, err, overflow
    );

    modport master (
        output clear, start, hex_mode, char_in, char_valid, num_end, result_ready,
        input  char_ready, result, result_valid, err, overflow
    );
endinterface

// File: rtl/ascii_num_parser.sv
// ascii_num_parser: ASCII decimal/hex digits -> signed DATA_WIDTH value; result_valid rises 1 cycle after num_end.
// char_ready drops while a result waits for result_ready; define ASCII_NUM_SAT_EN for saturation + overflow flag.
module ascii_num_parser #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DIGITS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    ascii_num_parser_if.slave bus
);
    localparam int AW = DATA_WIDTH + 5;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] acc;
        logic          sign;
        logic          first;
        logic [CW-1:0] cnt;
        logic          err;
    } num_t;

    state_t                state;
    state_t                state_nxt;
    num_t                  cur;
    num_t                  base;
    num_t                  nxt;
    logic                  char_rdy;
    logic                  hex_q;
    logic                  hex_cur;
    logic                  take;
    logic                  end_now;
    logic                  is_digit;
    logic                  dig_ok;
    logic [3:0]            dig_val;
    logic [AW-1:0]         prod;
    logic [DATA_WIDTH-1:0] acc_lo;
    logic [DATA_WIDTH-1:0] res_nxt;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  result_valid_q;
    logic                  err_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        char_rdy  = 1'b1;
        case (state)
            IDLE: begin
                // start together with num_end closes an empty/one-char number immediately
                if (bus.start) begin
                    state_nxt = bus.num_end ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (bus.num_end) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                char_rdy = 1'b0;
                if (result_valid_q && bus.result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (bus.clear) begin
            state_nxt = IDLE;
        end
    end

    // ---------------- character decode ----------------
    assign hex_cur = (state == IDLE) ? bus.hex_mode : hex_q;
    assign take    = bus.char_valid && ((state == ACCUM) || ((state == IDLE) && bus.start));
    assign end_now = bus.num_end    && ((state == ACCUM) || ((state == IDLE) && bus.start));

    always_comb begin
        is_digit = 1'b0;
        dig_val  = 4'd0;
        if (bus.char_in >= 8'h30 && bus.char_in <= 8'h39) begin
            is_digit = 1'b1;
            dig_val  = bus.char_in[3:0];
        end else if (hex_cur && ((bus.char_in >= 8'h61 && bus.char_in <= 8'h66) ||
                                 (bus.char_in >= 8'h41 && bus.char_in <= 8'h46))) begin
            is_digit = 1'b1;
            dig_val  = bus.char_in[3:0] + 4'd9;
        end
    end

    // ---------------- accumulate ----------------
    always_comb begin
        base = cur;
        if (state == IDLE) begin
            base       = '0;
            base.first = 1'b1;
        end
    end

    assign dig_ok = take && is_digit && (base.cnt < CW'(MAX_DIGITS));
    assign prod   = hex_cur ? ({base.acc[AW-5:0], 4'b0000} + AW'(dig_val))
                            : ((base.acc << 3) + (base.acc << 1) + AW'(dig_val));

    always_comb begin
        nxt = base;
        if (take) begin
            nxt.first = 1'b0;
            if (dig_ok) begin
                nxt.cnt = base.cnt + CW'(1);
                nxt.acc = prod;
            end else if (!is_digit && bus.char_in == 8'h2d && base.first) begin
                nxt.sign = 1'b1;
            end else begin
                nxt.err = 1'b1;
            end
        end
    end

    assign acc_lo = nxt.acc[DATA_WIDTH-1:0];

`ifdef ASCII_NUM_SAT_EN
    localparam logic [AW-1:0] POS_LIM = {{6{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [AW-1:0] NEG_LIM = {{5{1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic          ovf_cur;
    logic          ovf_nxt;
    logic          ovf_q;
    logic [AW-1:0] lim;

    // sign is fixed before any digit, so the limit is known when digits arrive
    assign lim = base.sign ? NEG_LIM : POS_LIM;

    always_comb begin
        ovf_nxt = (state == IDLE) ? 1'b0 : ovf_cur;
        if (dig_ok && (prod > lim)) begin
            ovf_nxt = 1'b1;
        end
    end

    always_comb begin
        res_nxt = nxt.sign ? -acc_lo : acc_lo;
        if (ovf_nxt) begin
            res_nxt = nxt.sign ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cur <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.clear) begin
            ovf_cur <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (state != HOLD) begin
                ovf_cur <= ovf_nxt;
            end
            if (end_now) begin
                ovf_q <= ovf_nxt;
            end
        end
    end

    assign bus.overflow = ovf_q;
`else
    always_comb begin
        res_nxt = nxt.sign ? -acc_lo : acc_lo;
    end

    assign bus.overflow = 1'b0;
`endif

    // ---------------- state / result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur            <= '0;
            hex_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else if (bus.clear) begin
            cur            <= '0;
            hex_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (state != HOLD) begin
                cur <= nxt;
            end
            if ((state == IDLE) && bus.start) begin
                hex_q <= bus.hex_mode;
            end
            if (end_now) begin
                result_q       <= res_nxt;
                result_valid_q <= 1'b1;
                err_q          <= nxt.err | (nxt.cnt == '0);
            end else if ((state == HOLD) && result_valid_q && bus.result_ready) begin
                result_valid_q <= 1'b0;
            end
        end
    end

    assign bus.char_ready   = char_rdy;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.err          = err_q;
endmodule
